// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the MCP4921-class DAC SPI transmitter.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    LATCH
  } dac_state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;

  // A/B=0, BUF=0, GAn=1 (1x gain), SHDNn=1 (active)
  localparam logic [3:0] DEFAULT_CONFIG_BITS = 4'b0011;

endpackage

// File: rtl/dac_spi_tick_gen.sv
// Phase counter emitting a one-cycle tick every CLK_DIV clocks while enabled.
module spi_tick_gen
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase_reg;

  // Held at zero while disabled so every frame starts on a fresh half-period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_reg <= '0;
    end else if (!enable || phase_reg == LAST) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + PW'(1);
    end
  end

  assign tick = enable && (phase_reg == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one sine sample per handshake into a mode-0 SPI DAC frame, then strobes LDAC.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int         SINE_SIZE   = 12,
  parameter int         CLK_DIV     = 4,
  parameter logic [3:0] CONFIG_BITS = DEFAULT_CONFIG_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SINE_SIZE-1:0] sampleIn,
  input  logic                 sampleValid,
  output logic                 sampleReady,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 csN,
  output logic                 ldacN,
  output logic                 busy,
  output logic                 frameDone
);

  localparam int PAD = DATA_BITS - SINE_SIZE;

  dac_state_e            state_reg, state_next;
  logic [3:0]            bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic                  sclk_reg, sclk_next;
  logic                  mosi_reg, mosi_next;
  logic                  csn_reg, csn_next;
  logic                  ldacn_reg, ldacn_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  ready_reg, ready_next;
  logic                  tick;
  logic [DATA_BITS-1:0]  data_load;
  logic [FRAME_BITS-1:0] frame_load;

  // Narrow samples are left-justified so they still span the DAC's full scale.
  assign data_load  = DATA_BITS'(sampleIn) << PAD;
  assign frame_load = {CONFIG_BITS, data_load};

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .enable(busy_reg),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      csn_reg     <= 1'b1;
      ldacn_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      csn_reg     <= csn_next;
      ldacn_reg   <= ldacn_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      ready_reg   <= ready_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    csn_next     = csn_reg;
    ldacn_next   = ldacn_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    ready_next   = ready_reg;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        csn_next   = 1'b1;
        sclk_next  = 1'b0;
        mosi_next  = 1'b0;
        busy_next  = 1'b0;
        if (sampleValid && ready_reg) begin
          state_next   = SHIFT;
          shift_next   = frame_load;
          mosi_next    = frame_load[FRAME_BITS-1];
          bit_cnt_next = 4'(FRAME_BITS - 1);
          csn_next     = 1'b0;
          ready_next   = 1'b0;
          busy_next    = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else begin
            // Falling edge: advance mosi so it is settled well before the next rise.
            sclk_next = 1'b0;
            if (bit_cnt_reg == 4'd0) begin
              state_next = HOLD;
              mosi_next  = 1'b0;
            end else begin
              bit_cnt_next = bit_cnt_reg - 4'd1;
              shift_next   = shift_reg << 1;
              mosi_next    = shift_reg[FRAME_BITS-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_next = LATCH;
          csn_next   = 1'b1;
          ldacn_next = 1'b0;
        end
      end
      LATCH: begin
        if (tick) begin
          state_next = IDLE;
          ldacn_next = 1'b1;
          done_next  = 1'b1;
          ready_next = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sampleReady = ready_reg;
  assign sclk        = sclk_reg;
  assign mosi        = mosi_reg;
  assign csN         = csn_reg;
  assign ldacN       = ldacn_reg;
  assign busy        = busy_reg;
  assign frameDone   = done_reg;

endmodule
